param_bus_datapath: RTL and testbench
=====================================

Name:
param_bus_datapath

Overview:
Parametrised successor to the single-bus CPU datapath. It contains the register file, PC, IR, Y, HI, LO, 2W-bit Z, MAR and MDR around one shared bus. New relative to the fixed 32-bit/16-register version: configurable width and register count, an R0-as-zero base-address mode, PC auto-increment, bus-contention detection, and a timed memory read/write handshake FSM feeding MDR.

Parameters:
DATA_W, 32, datapath and bus width in bits
NUM_REGS, 16, general register count (≥2)
ADDR_W, 9, MAR / memory address width (≤ DATA_W)
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before abort (≥1)

Ports:
clock  in  1  single clock, all state updates on rising edge
clear  in  1  synchronous active-high reset
reg_in  in  NUM_REGS  one-hot general-register load enables
reg_out  in  NUM_REGS  general-register bus drive enables
ld_en  in  8  loads {Zin,MDRin,MARin,LOin,HIin,Yin,IRin,PCin}, bit0=PCin
out_en  in  8  drives {Cout,InPortout,MDRout,PCout,ZLOout,ZHIout,LOout,HIout}, bit0=HIout
BAout  in  1  qualifies R0 read: R0 drives zero when BAout and reg_out[0]
IncPC  in  1  PC <= PC+1
Read  in  1  start memory read into MDR
Write  in  1  start memory write of MDR to MAR
mem_ready  in  1  memory completion strobe
Mdatain  in  DATA_W  memory read data
inport_data  in  DATA_W  input-port value
c_sign_ext  in  DATA_W  sign-extended immediate
alu_result  in  2*DATA_W  ALU result captured into Z
bus  out  DATA_W  current bus value
y_out  out  DATA_W  Y register (ALU A operand)
ir_out  out  DATA_W  IR register
mem_addr  out  ADDR_W  MAR register
mem_wdata  out  DATA_W  MDR register
mem_rd_req  out  1  read request, held until done/abort
mem_wr_req  out  1  write request, held until done/abort
mem_busy  out  1  FSM not IDLE
rd_done  out  1  one-cycle pulse when MDR captured read data
bus_conflict  out  1  sticky: >1 drive enable seen
mem_timeout  out  1  sticky: transaction aborted on timeout

Behaviour:
- clear (sync): every register, MDR, FSM (→IDLE), counter, all flags and outputs = 0. Applies mid-transaction: requests drop at the same edge.
- Bus is combinational. Exactly one enable asserted among reg_out|out_en → that source. None → 0.
- More than one enable → bus = 0. bus_conflict is set next edge and stays set until clear.
- R0 with BAout → 0; other sources drive their register.
- Loads: the bus is written on the edge where the enable is high; all loads are simultaneous.
- Zin captures alu_result: ZHI = upper DATA_W bits, ZLO = lower.
- MARin loads bus[ADDR_W-1:0].
- PC: PCin has priority over IncPC. IncPC alone gives PC+1 mod 2^DATA_W.
- FSM IDLE:
  - Read → RD_WAIT. Else Write → WR_WAIT. Read wins if both are high; Write is dropped.
  - mem_rd_req/mem_wr_req are registered: high from the first cycle in the WAIT state.
  - Counter reset to 0 on entry.
- RD_WAIT:
  - mem_ready → MDR <= Mdatain, rd_done=1 for one cycle, → IDLE.
  - Else counter+1. Counter reaching MEM_TIMEOUT → abort: MDR unchanged, mem_timeout set (sticky), → IDLE.
- WR_WAIT: same rules as RD_WAIT, with no MDR update and no rd_done.
- MDRin from bus:
  - Honoured in IDLE, including the same edge a Read starts.
  - Ignored while mem_busy; MDR stays stable during writes.
  - Read/Write asserted while busy are ignored (no queuing).
- mem_ready in IDLE is ignored.
- mem_addr/mem_wdata always reflect MAR/MDR.

Test Plan:
- Reset/transfer, DATA_W=32, NUM_REGS=16: clear, then R3 loaded 0x0000_00A5 via Cout. R3out + R7in → R7=0xA5; bus=0 with no enables.
- Base mode: R0=0x55. reg_out[0]+BAout+Yin → y_out=0. Without BAout → y_out=0x55.
- Contention: R1out+PCout same cycle → bus=0, bus_conflict=1 next cycle and stays set until clear.
- Read handshake: MAR=0x012, Read pulse, mem_ready on 3rd wait cycle with Mdatain=0xDEAD_BEEF → mem_rd_req high 3 cycles, MDR=0xDEADBEEF, rd_done pulse once.
- Timeout/priority: Read+Write together, mem_ready never → only mem_rd_req asserted; after 15 cycles abort, mem_timeout=1, MDR unchanged.
- PC/Z: PC=0xFFFF_FFFF with IncPC → 0. IncPC+PCin with bus=0x40 → 0x40. Zin with alu_result=0x1_0000_0002 → ZHI=1, ZLO=2.

Source files
------------

// File: rtl/param_bus_datapath.sv
// param_bus_datapath: single-bus CPU datapath with parametrised register file,
// contention detection and a timed memory read/write handshake feeding MDR.
module param_bus_datapath #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NUM_REGS-1:0]   reg_in,
    input  logic [NUM_REGS-1:0]   reg_out,
    input  logic [7:0]            ld_en,
    input  logic [7:0]            out_en,
    input  logic                  BAout,
    input  logic                  IncPC,
    input  logic                  Read,
    input  logic                  Write,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     Mdatain,
    input  logic [DATA_W-1:0]     inport_data,
    input  logic [DATA_W-1:0]     c_sign_ext,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]     bus,
    output logic [DATA_W-1:0]     y_out,
    output logic [DATA_W-1:0]     ir_out,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic                  mem_busy,
    output logic                  rd_done,
    output logic                  bus_conflict,
    output logic                  mem_timeout
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    localparam int NE = NUM_REGS + 8;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [DATA_W-1:0]   r_q [NUM_REGS];
    logic [DATA_W-1:0]   pc_q, ir_q, y_q, hi_q, lo_q, mdr_q, mdr_d, src;
    logic [2*DATA_W-1:0] z_q;
    logic [ADDR_W-1:0]   mar_q;
    logic [NE-1:0]       en;
    logic                multi, rd_done_q, rd_done_d, conflict_q, to_q, to_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    state_t              state_q, state_d;

    assign en    = {out_en, reg_out};
    assign multi = |(en & (en - NE'(1)));

    always_comb begin
        src = '0;
        for (int i = 0; i < NUM_REGS; i++)
            src |= (reg_out[i] && !(i == 0 && BAout)) ? r_q[i] : '0;
        src |= out_en[0] ? hi_q : '0;
        src |= out_en[1] ? lo_q : '0;
        src |= out_en[2] ? z_q[2*DATA_W-1:DATA_W] : '0;
        src |= out_en[3] ? z_q[DATA_W-1:0] : '0;
        src |= out_en[4] ? pc_q : '0;
        src |= out_en[5] ? mdr_q : '0;
        src |= out_en[6] ? inport_data : '0;
        src |= out_en[7] ? c_sign_ext : '0;
    end

    assign bus = multi ? '0 : src;

    // Counter is held at zero in IDLE, so every WAIT entry starts from zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        mdr_d     = mdr_q;
        rd_done_d = 1'b0;
        to_d      = to_q;
        if (state_q == IDLE) begin
            mdr_d   = ld_en[6] ? bus : mdr_q;
            state_d = Read ? RD_WAIT : Write ? WR_WAIT : IDLE;
        end else if (mem_ready) begin
            state_d   = IDLE;
            mdr_d     = (state_q == RD_WAIT) ? Mdatain : mdr_q;
            rd_done_d = (state_q == RD_WAIT);
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            state_d = IDLE;
            to_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            y_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            z_q        <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            rd_done_q  <= 1'b0;
            conflict_q <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) if (reg_in[i]) r_q[i] <= bus;
            pc_q       <= ld_en[0] ? bus : IncPC ? pc_q + DATA_W'(1) : pc_q;
            ir_q       <= ld_en[1] ? bus : ir_q;
            y_q        <= ld_en[2] ? bus : y_q;
            hi_q       <= ld_en[3] ? bus : hi_q;
            lo_q       <= ld_en[4] ? bus : lo_q;
            mar_q      <= ld_en[5] ? bus[ADDR_W-1:0] : mar_q;
            z_q        <= ld_en[7] ? alu_result : z_q;
            mdr_q      <= mdr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rd_done_q  <= rd_done_d;
            conflict_q <= conflict_q | multi;
            to_q       <= to_d;
        end
    end

    assign y_out        = y_q;
    assign ir_out       = ir_q;
    assign mem_addr     = mar_q;
    assign mem_wdata    = mdr_q;
    assign mem_rd_req   = (state_q == RD_WAIT);
    assign mem_wr_req   = (state_q == WR_WAIT);
    assign mem_busy     = (state_q != IDLE);
    assign rd_done      = rd_done_q;
    assign bus_conflict = conflict_q;
    assign mem_timeout  = to_q;
endmodule

// File: tb/tb_param_bus_datapath.sv
// tb_param_bus_datapath: directed-vector bench for param_bus_datapath at default parameters.
module tb_param_bus_datapath;
    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] reg_in, reg_out;
    logic [7:0]  ld_en, out_en;
    logic        BAout, IncPC, Read, Write, mem_ready;
    logic [31:0] Mdatain, inport_data, c_sign_ext;
    logic [63:0] alu_result;
    logic [31:0] bus, y_out, ir_out, mem_wdata;
    logic [8:0]  mem_addr;
    logic        mem_rd_req, mem_wr_req, mem_busy, rd_done, bus_conflict, mem_timeout;
    int          n_cmp = 0, n_err = 0;

    param_bus_datapath dut (
        .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
        .ld_en(ld_en), .out_en(out_en), .BAout(BAout), .IncPC(IncPC),
        .Read(Read), .Write(Write), .mem_ready(mem_ready), .Mdatain(Mdatain),
        .inport_data(inport_data), .c_sign_ext(c_sign_ext), .alu_result(alu_result),
        .bus(bus), .y_out(y_out), .ir_out(ir_out), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_busy(mem_busy), .rd_done(rd_done), .bus_conflict(bus_conflict),
        .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reg_in = '0; reg_out = '0; ld_en = '0; out_en = '0;
        BAout = 0; IncPC = 0; Read = 0; Write = 0; mem_ready = 0;
    endtask

    task automatic c_to(input logic [31:0] v, input logic [15:0] rin, input logic [7:0] ld);
        idle();
        c_sign_ext = v; out_en = 8'h80; reg_in = rin; ld_en = ld;
        step();
        idle();
    endtask

    initial begin
        int k;
        logic wr_seen;
        idle();
        Mdatain = '0; inport_data = 32'h0BAD_F00D; c_sign_ext = '0; alu_result = '0;
        clear = 1;
        step();
        step();
        clear = 0;
        check("rst_bus", bus, 0);
        check("rst_y", y_out, 0);
        check("rst_mar", mem_addr, 0);
        check("rst_mdr", mem_wdata, 0);
        check("rst_flags", {mem_rd_req, mem_wr_req, mem_busy, rd_done, bus_conflict, mem_timeout}, 0);

        c_to(32'hA5, 16'h0008, 8'h00);
        reg_out = 16'h0008; reg_in = 16'h0080;
        #1 check("r3_bus", bus, 32'hA5);
        step();
        idle();
        reg_out = 16'h0080; ld_en = 8'h06;
        step();
        idle();
        check("r7_y", y_out, 32'hA5);
        check("r7_ir", ir_out, 32'hA5);
        #1 check("bus_none", bus, 0);

        c_to(32'h55, 16'h0001, 8'h00);
        reg_out = 16'h0001; BAout = 1; ld_en = 8'h04;
        step();
        idle();
        check("ba_y_zero", y_out, 0);
        reg_out = 16'h0001; ld_en = 8'h04;
        step();
        idle();
        check("r0_y", y_out, 32'h55);

        c_to(32'hFFFF_FFFF, '0, 8'h01);
        IncPC = 1;
        step();
        idle();
        out_en = 8'h10;
        #1 check("pc_wrap", bus, 0);
        idle();
        c_sign_ext = 32'h40; out_en = 8'h80; ld_en = 8'h01; IncPC = 1;
        step();
        idle();
        out_en = 8'h10;
        #1 check("pc_ld_prio", bus, 32'h40);
        idle();

        alu_result = 64'h1_0000_0002; ld_en = 8'h80;
        step();
        idle();
        out_en = 8'h04;
        #1 check("zhi", bus, 1);
        out_en = 8'h08;
        #1 check("zlo", bus, 2);
        idle();
        c_to(32'h1234, '0, 8'h08);
        c_to(32'h5678, '0, 8'h10);
        out_en = 8'h01;
        #1 check("hi", bus, 32'h1234);
        out_en = 8'h02;
        #1 check("lo", bus, 32'h5678);
        out_en = 8'h40;
        #1 check("inport", bus, 32'h0BAD_F00D);
        idle();

        c_to(32'hFFFF_F012, '0, 8'h20);
        check("mar", mem_addr, 9'h012);
        c_to(32'h11, '0, 8'h40);
        check("mdr_ld", mem_wdata, 32'h11);

        Read = 1;
        step();
        idle();
        check("rd_req_c1", {mem_rd_req, mem_wr_req, mem_busy}, 3'b101);
        c_sign_ext = 32'h77; out_en = 8'h80; ld_en = 8'h40;
        step();
        idle();
        check("rd_req_c2", mem_rd_req, 1);
        check("mdr_busy_hold", mem_wdata, 32'h11);
        mem_ready = 1; Mdatain = 32'hDEAD_BEEF;
        step();
        idle();
        check("rd_data", mem_wdata, 32'hDEAD_BEEF);
        check("rd_done_hi", {rd_done, mem_rd_req, mem_busy}, 3'b100);
        mem_ready = 1; Mdatain = 32'h0;
        step();
        idle();
        check("rd_done_lo", rd_done, 0);
        check("idle_ready_ign", mem_wdata, 32'hDEAD_BEEF);

        Write = 1;
        step();
        idle();
        check("wr_req", {mem_rd_req, mem_wr_req}, 2'b01);
        mem_ready = 1; Mdatain = 32'h1;
        step();
        idle();
        check("wr_done", {mem_wr_req, rd_done, mem_busy}, 0);
        check("wr_mdr", mem_wdata, 32'hDEAD_BEEF);

        Read = 1; Write = 1;
        step();
        idle();
        k = 0;
        wr_seen = 0;
        while (mem_rd_req && k < 40) begin
            if (mem_wr_req) wr_seen = 1;
            k++;
            step();
        end
        check("to_cycles", k, 15);
        check("to_no_wr", wr_seen, 0);
        check("to_flag", {mem_timeout, mem_busy}, 2'b10);
        check("to_mdr", mem_wdata, 32'hDEAD_BEEF);

        reg_out = 16'h0002; out_en = 8'h10;
        #1 check("conf_bus", bus, 0);
        check("conf_pre", bus_conflict, 0);
        step();
        idle();
        check("conf_set", bus_conflict, 1);
        step();
        check("conf_sticky", bus_conflict, 1);

        Read = 1;
        step();
        idle();
        check("pre_clr_req", mem_rd_req, 1);
        clear = 1;
        step();
        clear = 0;
        check("clr_flags", {mem_rd_req, mem_wr_req, mem_busy, rd_done, bus_conflict, mem_timeout}, 0);
        check("clr_regs", {y_out, mem_wdata}, 0);
        check("clr_mar", mem_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
